// File: rtl/bp_train_scheduler.sv
// In-order branch train sequencer: issues predictor lookups, checkpoints them in
// a circular in-flight queue, and retires resolved outcomes into the training port.
module bp_train_scheduler #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 7,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fe_req_valid,
  input  logic [PC_W-1:0]             fe_req_pc,
  output logic                        fe_req_ready,
  output logic                        fe_pred_taken,
  output logic                        bp_predict_valid,
  output logic [PC_W-1:0]             bp_predict_pc,
  input  logic                        bp_predict_taken,
  input  logic [PC_W-1:0]             bp_predict_history,
  input  logic                        ex_resolve_valid,
  input  logic                        ex_resolve_taken,
  output logic                        ex_resolve_ready,
  output logic                        bp_train_valid,
  output logic                        bp_train_taken,
  output logic                        bp_train_mispredicted,
  output logic [PC_W-1:0]             bp_train_history,
  output logic [PC_W-1:0]             bp_train_pc,
  output logic                        flush,
  output logic [$clog2(DEPTH):0]      inflight_count,
  output logic [CNT_W-1:0]            stat_branches,
  output logic [CNT_W-1:0]            stat_mispredicts
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [0:0]      ST_RUN     = 1'b0;
  localparam logic [0:0]      ST_RECOVER = 1'b1;

  logic [PC_W-1:0] q_pc    [DEPTH];
  logic [PC_W-1:0] q_hist  [DEPTH];
  logic            q_taken [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic          push, pop, mispred;

  assign fe_req_ready     = (state == ST_RUN) && (count < FULL_COUNT);
  assign bp_predict_valid = fe_req_valid & fe_req_ready;
  assign bp_predict_pc    = fe_req_pc;
  assign fe_pred_taken    = bp_predict_taken;
  assign ex_resolve_ready = (count != '0);
  assign inflight_count   = count;

  assign push    = bp_predict_valid;
  assign pop     = ex_resolve_valid & ex_resolve_ready;
  assign mispred = pop & (q_taken[rd_ptr] != ex_resolve_taken);

  // NOTE: queue storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fe_req_pc;
      q_hist[wr_ptr]  <= bp_predict_history;
      q_taken[wr_ptr] <= bp_predict_taken;
    end
  end

  // A mispredict squashes the whole queue, including a same-cycle wrong-path push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispred) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_RUN;
      flush                 <= 1'b0;
      bp_train_valid        <= 1'b0;
      bp_train_taken        <= 1'b0;
      bp_train_mispredicted <= 1'b0;
      bp_train_history      <= '0;
      bp_train_pc           <= '0;
    end else begin
      flush          <= mispred;
      bp_train_valid <= pop;
      if (pop) begin
        bp_train_taken        <= ex_resolve_taken;
        bp_train_mispredicted <= mispred;
        bp_train_history      <= q_hist[rd_ptr];
        bp_train_pc           <= q_pc[rd_ptr];
      end
      case (state)
        ST_RUN:     state <= mispred ? ST_RECOVER : ST_RUN;
        ST_RECOVER: state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && stat_branches != CNT_MAX)        stat_branches    <= stat_branches + 1'b1;
      if (mispred && stat_mispredicts != CNT_MAX) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_train_scheduler.sv
// Self-checking bench for bp_train_scheduler: directed vector table, reset and
// saturation sequences, then random traffic against a queue-based reference model.
module tb_bp_train_scheduler;

  localparam int DEPTH = 4;
  localparam int PC_W  = 7;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic fe_req_valid;
  logic [PC_W-1:0] fe_req_pc;
  logic bp_predict_taken;
  logic [PC_W-1:0] bp_predict_history;
  logic ex_resolve_valid, ex_resolve_taken;

  logic fe_req_ready, fe_pred_taken, bp_predict_valid, ex_resolve_ready;
  logic [PC_W-1:0] bp_predict_pc, bp_train_history, bp_train_pc;
  logic bp_train_valid, bp_train_taken, bp_train_mispredicted, flush;
  logic [CW-1:0] inflight_count;
  logic [15:0] stat_branches, stat_mispredicts;

  logic s_fe_req_ready, s_fe_pred_taken, s_bp_predict_valid, s_ex_resolve_ready;
  logic [PC_W-1:0] s_bp_predict_pc, s_bp_train_history, s_bp_train_pc;
  logic s_bp_train_valid, s_bp_train_taken, s_bp_train_mispredicted, s_flush;
  logic [CW-1:0] s_inflight_count;
  logic [1:0] s_stat_branches, s_stat_mispredicts;

  bp_train_scheduler #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fe_req_valid(fe_req_valid), .fe_req_pc(fe_req_pc), .fe_req_ready(fe_req_ready),
    .fe_pred_taken(fe_pred_taken), .bp_predict_valid(bp_predict_valid),
    .bp_predict_pc(bp_predict_pc), .bp_predict_taken(bp_predict_taken),
    .bp_predict_history(bp_predict_history),
    .ex_resolve_valid(ex_resolve_valid), .ex_resolve_taken(ex_resolve_taken),
    .ex_resolve_ready(ex_resolve_ready),
    .bp_train_valid(bp_train_valid), .bp_train_taken(bp_train_taken),
    .bp_train_mispredicted(bp_train_mispredicted), .bp_train_history(bp_train_history),
    .bp_train_pc(bp_train_pc), .flush(flush), .inflight_count(inflight_count),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Narrow-counter instance on the same stimulus, used for saturation checks.
  bp_train_scheduler #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .fe_req_valid(fe_req_valid), .fe_req_pc(fe_req_pc), .fe_req_ready(s_fe_req_ready),
    .fe_pred_taken(s_fe_pred_taken), .bp_predict_valid(s_bp_predict_valid),
    .bp_predict_pc(s_bp_predict_pc), .bp_predict_taken(bp_predict_taken),
    .bp_predict_history(bp_predict_history),
    .ex_resolve_valid(ex_resolve_valid), .ex_resolve_taken(ex_resolve_taken),
    .ex_resolve_ready(s_ex_resolve_ready),
    .bp_train_valid(s_bp_train_valid), .bp_train_taken(s_bp_train_taken),
    .bp_train_mispredicted(s_bp_train_mispredicted), .bp_train_history(s_bp_train_history),
    .bp_train_pc(s_bp_train_pc), .flush(s_flush), .inflight_count(s_inflight_count),
    .stat_branches(s_stat_branches), .stat_mispredicts(s_stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight branches as a queue of checkpoints.
  typedef struct {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] hist;
    logic            taken;
  } entry_t;

  entry_t          mq[$];
  bit              m_recover;
  logic            m_tv, m_tt, m_tmis, m_flush;
  logic [PC_W-1:0] m_thist, m_tpc;
  int              m_br, m_mis, m_br2, m_mis2;

  // Snapshots of the last step, used by the table comparisons.
  logic            c_rdy, c_pv, c_rrdy, c_tv, c_tmis, c_fl;
  logic [PC_W-1:0] c_tpc, c_thist;
  logic [CW-1:0]   c_cnt;

  task automatic model_reset();
    mq.delete();
    m_recover = 0;
    m_tv = 0; m_tt = 0; m_tmis = 0; m_flush = 0;
    m_thist = '0; m_tpc = '0;
    m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
  endtask

  task automatic step(input logic fv, input logic [PC_W-1:0] pc, input logic pt,
                      input logic [PC_W-1:0] ph, input logic rv, input logic rt);
    bit e_rdy, e_pv, e_rrdy, do_pop, do_mis;
    fe_req_valid       = fv;
    fe_req_pc          = pc;
    bp_predict_taken   = pt;
    bp_predict_history = ph;
    ex_resolve_valid   = rv;
    ex_resolve_taken   = rt;
    #1;
    e_rdy  = !m_recover && (mq.size() < DEPTH);
    e_pv   = fv && e_rdy;
    e_rrdy = (mq.size() != 0);
    check("fe_req_ready", 32'(fe_req_ready), 32'(e_rdy));
    check("bp_predict_valid", 32'(bp_predict_valid), 32'(e_pv));
    check("ex_resolve_ready", 32'(ex_resolve_ready), 32'(e_rrdy));
    check("bp_predict_pc", 32'(bp_predict_pc), 32'(pc));
    check("fe_pred_taken", 32'(fe_pred_taken), 32'(pt));
    c_rdy = fe_req_ready; c_pv = bp_predict_valid; c_rrdy = ex_resolve_ready;

    do_pop = rv && e_rrdy;
    do_mis = do_pop && (mq[0].taken != rt);
    m_tv = do_pop;
    m_flush = do_mis;
    m_recover = do_mis;
    if (do_pop) begin
      m_tt = rt; m_tmis = do_mis; m_thist = mq[0].hist; m_tpc = mq[0].pc;
      void'(mq.pop_front());
      m_br  = (m_br  < 65535) ? m_br  + 1 : m_br;
      m_br2 = (m_br2 < 3)     ? m_br2 + 1 : m_br2;
    end
    if (do_mis) begin
      mq.delete();
      m_mis  = (m_mis  < 65535) ? m_mis  + 1 : m_mis;
      m_mis2 = (m_mis2 < 3)     ? m_mis2 + 1 : m_mis2;
    end else if (e_pv) begin
      mq.push_back('{pc: pc, hist: ph, taken: pt});
    end

    @(posedge clk);
    #1;
    check("bp_train_valid", 32'(bp_train_valid), 32'(m_tv));
    check("bp_train_taken", 32'(bp_train_taken), 32'(m_tt));
    check("bp_train_mispredicted", 32'(bp_train_mispredicted), 32'(m_tmis));
    check("bp_train_history", 32'(bp_train_history), 32'(m_thist));
    check("bp_train_pc", 32'(bp_train_pc), 32'(m_tpc));
    check("flush", 32'(flush), 32'(m_flush));
    check("inflight_count", 32'(inflight_count), 32'(mq.size()));
    check("stat_branches", 32'(stat_branches), 32'(m_br));
    check("stat_mispredicts", 32'(stat_mispredicts), 32'(m_mis));
    check("sat_stat_branches", 32'(s_stat_branches), 32'(m_br2));
    check("sat_stat_mispredicts", 32'(s_stat_mispredicts), 32'(m_mis2));
    c_tv = bp_train_valid; c_tmis = bp_train_mispredicted; c_fl = flush;
    c_tpc = bp_train_pc; c_thist = bp_train_history; c_cnt = inflight_count;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic fv; logic [PC_W-1:0] pc; logic pt; logic [PC_W-1:0] ph; logic rv; logic rt;
    logic e_rdy; logic e_pv; logic e_rrdy;
    logic e_tv; logic [PC_W-1:0] e_tpc; logic [PC_W-1:0] e_thist; logic e_tmis; logic e_fl;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    fe_req_valid = 0; fe_req_pc = '0; bp_predict_taken = 0; bp_predict_history = '0;
    ex_resolve_valid = 0; ex_resolve_taken = 0;
    model_reset();
    #1;
    check("reset fe_req_ready", 32'(fe_req_ready), 32'd1);
    check("reset ex_resolve_ready", 32'(ex_resolve_ready), 32'd0);
    check("reset bp_train_valid", 32'(bp_train_valid), 32'd0);
    check("reset flush", 32'(flush), 32'd0);
    check("reset inflight_count", 32'(inflight_count), 32'd0);
    check("reset stat_branches", 32'(stat_branches), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //            fv pc     pt ph     rv rt   rdy pv rrdy  tv tpc    thist  tmis fl cnt
    tbl.push_back('{1, 7'h10, 0, 7'h01, 0, 0,  1, 1, 0,    0, 7'h00, 7'h00, 0, 0, 1});
    tbl.push_back('{1, 7'h11, 0, 7'h02, 0, 0,  1, 1, 1,    0, 7'h00, 7'h00, 0, 0, 2});
    tbl.push_back('{1, 7'h12, 0, 7'h03, 0, 0,  1, 1, 1,    0, 7'h00, 7'h00, 0, 0, 3});
    tbl.push_back('{1, 7'h13, 0, 7'h04, 0, 0,  1, 1, 1,    0, 7'h00, 7'h00, 0, 0, 4});
    tbl.push_back('{1, 7'h14, 0, 7'h05, 0, 0,  0, 0, 1,    0, 7'h00, 7'h00, 0, 0, 4});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 1, 0,  0, 0, 1,    1, 7'h10, 7'h01, 0, 0, 3});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 1, 0,  1, 0, 1,    1, 7'h11, 7'h02, 0, 0, 2});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 1, 0,  1, 0, 1,    1, 7'h12, 7'h03, 0, 0, 1});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 1, 0,  1, 0, 1,    1, 7'h13, 7'h04, 0, 0, 0});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 1, 0,  1, 0, 0,    0, 7'h00, 7'h00, 0, 0, 0});
    tbl.push_back('{1, 7'h20, 0, 7'h33, 0, 0,  1, 1, 0,    0, 7'h00, 7'h00, 0, 0, 1});
    tbl.push_back('{1, 7'h21, 0, 7'h34, 0, 0,  1, 1, 1,    0, 7'h00, 7'h00, 0, 0, 2});
    tbl.push_back('{1, 7'h22, 0, 7'h35, 0, 0,  1, 1, 1,    0, 7'h00, 7'h00, 0, 0, 3});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 1, 1,  1, 0, 1,    1, 7'h20, 7'h33, 1, 1, 0});
    tbl.push_back('{1, 7'h30, 0, 7'h40, 0, 0,  0, 0, 0,    0, 7'h00, 7'h00, 0, 0, 0});
    tbl.push_back('{1, 7'h30, 0, 7'h40, 0, 0,  1, 1, 0,    0, 7'h00, 7'h00, 0, 0, 1});
    tbl.push_back('{1, 7'h31, 1, 7'h41, 1, 0,  1, 1, 1,    1, 7'h30, 7'h40, 0, 0, 1});
    tbl.push_back('{1, 7'h32, 0, 7'h42, 1, 0,  1, 1, 1,    1, 7'h31, 7'h41, 1, 1, 0});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 0, 0,  0, 0, 0,    0, 7'h00, 7'h00, 0, 0, 0});
    tbl.push_back('{0, 7'h00, 0, 7'h00, 0, 0,  1, 0, 0,    0, 7'h00, 7'h00, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].fv, tbl[i].pc, tbl[i].pt, tbl[i].ph, tbl[i].rv, tbl[i].rt);
      check($sformatf("vec%0d ready", i), 32'(c_rdy), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d pvalid", i), 32'(c_pv), 32'(tbl[i].e_pv));
      check($sformatf("vec%0d rready", i), 32'(c_rrdy), 32'(tbl[i].e_rrdy));
      check($sformatf("vec%0d tvalid", i), 32'(c_tv), 32'(tbl[i].e_tv));
      check($sformatf("vec%0d flush", i), 32'(c_fl), 32'(tbl[i].e_fl));
      check($sformatf("vec%0d count", i), 32'(c_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_tv) begin
        check($sformatf("vec%0d tpc", i), 32'(c_tpc), 32'(tbl[i].e_tpc));
        check($sformatf("vec%0d thist", i), 32'(c_thist), 32'(tbl[i].e_thist));
        check($sformatf("vec%0d tmis", i), 32'(c_tmis), 32'(tbl[i].e_tmis));
      end
    end
    check("table stat_branches", 32'(stat_branches), 32'd7);
    check("table stat_mispredicts", 32'(stat_mispredicts), 32'd2);

    // Mid-operation reset with two entries in flight and a train pulse pending.
    step(1'b1, 7'h50, 1'b0, 7'h60, 1'b0, 1'b0);
    step(1'b1, 7'h51, 1'b0, 7'h61, 1'b0, 1'b0);
    step(1'b1, 7'h52, 1'b0, 7'h62, 1'b0, 1'b0);
    step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    fe_req_valid = 0; ex_resolve_valid = 0;
    #1;
    check("midreset inflight_count", 32'(inflight_count), 32'd0);
    check("midreset bp_train_valid", 32'(bp_train_valid), 32'd0);
    check("midreset flush", 32'(flush), 32'd0);
    check("midreset fe_req_ready", 32'(fe_req_ready), 32'd1);
    check("midreset ex_resolve_ready", 32'(ex_resolve_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();

    // Five mispredicted retires saturate the narrow counters at 3.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 7'(8'h60 + k), 1'b0, 7'(k), 1'b0, 1'b0);
      step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
      idle();
    end
    check("sat branches held", 32'(s_stat_branches), 32'd3);
    check("sat mispredicts held", 32'(s_stat_mispredicts), 32'd3);
    check("wide mispredicts", 32'(stat_mispredicts), 32'd5);

    for (int n = 0; n < 400; n++) begin
      step(1'(($urandom % 4) != 0), 7'($urandom), 1'($urandom), 7'($urandom),
           1'($urandom), 1'(($urandom % 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
